// File: rtl/param_stack.sv
// Parametrised LIFO stack with replace-top, occupancy count and sticky ovf/unf flags.
// Define PARAM_STACK_PEEK_EN to add the stack-relative peek_idx/peek_data read port.
module param_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr_err,
`ifdef PARAM_STACK_PEEK_EN
  input  logic [CNT_W-2:0] peek_idx,
  output logic [WIDTH-1:0] peek_data,
`endif
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned AW = CNT_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;

  // Low bits of count wrap to 0 when full, so subtracting 1 still lands on DEPTH-1.
  assign top_idx = count_q[AW-1:0] - AW'(1);

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign rdata = empty ? '0 : mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;
    we      = 1'b0;
    waddr   = '0;
    if (push && pop) begin
      we = 1'b1;
      if (!empty) begin
        waddr = top_idx;
      end else begin
        waddr   = '0;
        count_d = CNT_W'(1);
      end
    end else if (push) begin
      if (!full) begin
        we      = 1'b1;
        waddr   = count_q[AW-1:0];
        count_d = count_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop) begin
      if (!empty) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never cleared; a write is dropped while reset is held.
  always_ff @(negedge clk) begin
    if (we && rst_n) begin
      mem_q[waddr] <= wdata;
    end
  end

`ifdef PARAM_STACK_PEEK_EN
  logic [AW-1:0] peek_addr;
  assign peek_addr = top_idx - peek_idx;
  assign peek_data = ({1'b0, peek_idx} < count_q) ? mem_q[peek_addr] : '0;
`endif

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack for PUSH/POP/CALL/RET data in the CPU datapath; successor to the fixed 32x1024 stack.
- Adds configurable width and depth, combined push+pop as a replace-top operation, occupancy count, and sticky overflow/underflow error flags.
- Top of stack is always visible on rdata.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 1024, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, localparam; width of the count and the stack pointer, with an extra bit so DEPTH itself is representable.

Ports:
- clk  input  1  system clock; all state updates on negedge clk.
- rst_n  input  1  reset.
- push  input  1  write wdata onto the stack.
- pop  input  1  remove the top entry.
- wdata  input  WIDTH  data to push.
- clr_err  input  1  clears the sticky ovf/unf flags.
- rdata  output  WIDTH  current top-of-stack; combinational.
- count  output  CNT_W  number of valid entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- ovf  output  1  sticky: push attempted while full.
- unf  output  1  sticky: pop attempted while empty.

Behaviour:
- Clocking: reset is asynchronous and active-low on rst_n; single clock clk. All registers and memory writes update on negedge clk, so the CPU sees new state by the next posedge.
- Reset: count=0, ovf=0, unf=0, so empty=1 and full=0. Memory contents are not cleared. rdata reads 0 while empty.
- Reset mid-operation: any push/pop in flight is discarded, and count returns to 0 immediately (asynchronous).
- Storage: mem[0..DEPTH-1], with sp = count. A push writes mem[count]; top of stack is mem[count-1].
- rdata = empty ? 0 : mem[count-1]. Latency: a pushed value appears on rdata right after the negedge that writes it.
- Operations, per negedge, in priority order:
  1. push & pop & ~empty: replace top. mem[count-1] <= wdata; count unchanged; no error.
  2. push & pop & empty: treated as a plain push. mem[0] <= wdata; count=1; unf not set.
  3. push & ~pop & ~full: mem[count] <= wdata; count+1.
  4. push & ~pop & full: memory and count unchanged; ovf <= 1.
  5. pop & ~push & ~empty: count-1. Memory is not cleared.
  6. pop & ~push & empty: count stays 0; unf <= 1.
  7. Neither asserted: hold.
- Error flags:
  - ovf and unf stay set until clr_err or reset.
  - clr_err in the same cycle as a new error event: the set wins (flag reads 1 after the edge).
- Count never wraps: it is saturated at 0 and at DEPTH by rules 4 and 6.
- full and empty are combinational decodes of count.

Optional Feature:
- Macro: PARAM_STACK_PEEK_EN.
- When defined, adds two ports:
  - peek_idx  input  CNT_W-1 bits.
  - peek_data  output  WIDTH.
- peek_data = mem[count-1-peek_idx] when peek_idx < count, else 0. It is combinational and used for stack-relative operand reads (e.g. SP+n).
- Pushes, pops and flags are unaffected by peeking.
- When not defined, neither port exists and no peek mux logic is generated.

Test Plan:
- Reset, then fill and drain (WIDTH=32, DEPTH=4): push 0x11, 0x22, 0x33, 0x44 -> count=4, full=1, rdata=0x44. Then pop x4 -> rdata sequence 0x33, 0x22, 0x11, then 0; empty=1; ovf=unf=0.
- Overflow: with the stack full, push 0x55 -> count stays 4, rdata=0x44, ovf=1. Then pop -> rdata=0x33 and ovf stays 1. Then clr_err -> ovf=0.
- Underflow: from empty, pop -> count=0, unf=1, rdata=0. Then assert clr_err and pop on the same edge -> unf stays 1.
- Replace top: push 0xA, push 0xB, then push+pop with 0xC -> count=2, rdata=0xC. Then pop -> rdata=0xA. Separately, push+pop when empty with 0xD -> count=1, rdata=0xD, unf=0.
- Async reset: with count=3, drop rst_n between clock edges -> count=0, empty=1, rdata=0, flags 0 immediately. Then push 0x77 -> rdata=0x77, count=1.
- PARAM_STACK_PEEK_EN: push 0x1, 0x2, 0x3 -> peek_idx=0 gives 0x3, peek_idx=2 gives 0x1, peek_idx=3 gives 0. With the macro undefined, the bench compiles without the peek ports.
